sfifo_pkt: RTL and testbench
============================

# sfifo_pkt

Parameterised synchronous packet FIFO: the successor to the team's plain synchronous FIFO, adding valid/ready handshakes on both sides, store-and-forward packet commit (readers see only complete packets), explicit and automatic packet discard, runtime thresholds and a resident-packet count. Sits between packet producers (parsers, DMA engines) and consumers that must never observe a partial or dropped packet.

## Interface
- DEPTH, 4: entries, >=2
- WIDTH, 8: data bits per beat, >=1
- NO_DATA_RST, 0: 0 resets storage; 1 storage flops not reset
- NV_WIDTH, $clog2(DEPTH)+1: count width; derived, do not override
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear; highest priority
- wr_vld / wr_rdy  in / out  1 / 1  write handshake
- wr_data  in  WIDTH  beat data
- wr_eop  in  1  last beat of packet
- wr_drop  in  1  discard packet in progress
- rd_vld / rd_rdy  out / in  1 / 1  read handshake
- rd_data  out  WIDTH  head beat data
- rd_eop  out  1  head beat is last of packet
- fthresh, ethresh  in  NV_WIDTH  runtime thresholds, quasi-static
- full, tfull, empty, tempty  out  1  status flags
- num_vld  out  NV_WIDTH  committed unread beats
- num_used  out  NV_WIDTH  committed + uncommitted beats
- num_pkts  out  NV_WIDTH  complete packets resident
- pkt_dropped  out  1  one-cycle pulse per dropped packet
- err_ovsz  out  1  sticky: packet exceeded DEPTH

## Operation
- Storage: DEPTH x (WIDTH+1); eop stored with data. wr_ptr (speculative), cmt_ptr (commit), rd_ptr; all wrap DEPTH-1 -> 0.
- u = uncommitted beat count (0..DEPTH), internal.
- Write FSM: IDLE (u==0), PKT (u>0), DISCARD (swallowing beats of a dropped packet).
- wr_rdy = (num_used < DEPTH) | (state==DISCARD); combinational from registered state.
- Accepted beat (wr_vld & wr_rdy) in IDLE/PKT, no wr_drop: stored at wr_ptr, wr_ptr++. With wr_eop: cmt_ptr <= wr_ptr+1, num_vld += u+1, num_pkts++, u <= 0, -> IDLE. Else u++, -> PKT.
- wr_drop in PKT, or in IDLE together with an accepted beat: wr_ptr <= cmt_ptr, u <= 0, concurrent beat discarded even if eop, pkt_dropped pulse, -> IDLE. wr_drop in IDLE with no beat, or in DISCARD: no effect.
- Oversize: PKT with u==DEPTH -> wr_ptr <= cmt_ptr, u <= 0, err_ovsz <= 1, pkt_dropped pulse, -> DISCARD. A DEPTH-beat packet whose DEPTH-th beat has eop commits normally.
- DISCARD: wr_rdy=1, beats consumed and not stored; eop beat -> IDLE.
- Read: rd_vld = num_vld != 0; rd_data/rd_eop muxed from entry rd_ptr. Accept (rd_vld & rd_rdy): rd_ptr++, num_vld--, num_used--; if rd_eop, num_pkts--.
- Commit and read same cycle: num_vld_nxt = num_vld + (u+1) - 1.
- num_used_nxt = num_used + accepted-stored beat - read - (u if dropped); never exceeds DEPTH.
- Flags from next-state counts: full = num_used==DEPTH; empty = num_vld==0; tfull = num_used >= fthresh; tempty = num_vld <= ethresh.
- flush: all pointers, counts and u to 0, state IDLE, err_ovsz cleared, no pulse; overrides any concurrent write, read, drop or commit.
- Storage with NO_DATA_RST=1 is don't-care until written; rd_data is don't-care whenever rd_vld=0.

## Timing
- Reset values: wr_rdy=1, rd_vld=0, rd_data=0 (NO_DATA_RST=0), rd_eop=0, full=0, tfull=(fthresh==0), empty=1, tempty=1, all counts 0, pkt_dropped=0, err_ovsz=0, state IDLE.
- Commit latency: eop beat accepted in cycle N -> rd_vld=1 in N+1; first beat readable in N+1 regardless of packet length.
- Status, counts, pkt_dropped, err_ovsz registered: reflect events of cycle N in N+1.
- Handshakes: valid/ready combinational from flops only; no input-to-output combinational path except rd_data/rd_eop follow rd_ptr flops.
- Full throughput: one write and one read per cycle sustained once packets are committed.
- rst_n assertion mid-packet: immediate asynchronous return to reset values; partial packet lost, no pulse.

## Test plan
- DEPTH=4: write 3 beats (0x11,0x22,0x33 eop) -> rd_vld stays 0 until cycle after 0x33; num_vld=3, num_pkts=1; read all -> empty=1, num_pkts=0.
- Write 2 beats no eop, assert wr_drop -> pkt_dropped one pulse, num_used=0, rd_vld never rises; next packet 0xAA eop reads back 0xAA.
- 5 beats no eop into empty DEPTH=4 -> 4 beats stored, then err_ovsz=1, num_used=0, wr_rdy=1, beat 5 and later beats swallowed until eop; next packet delivered intact.
- 4-beat packet fills FIFO, consumer reads with rd_rdy=1 while 2nd packet written concurrently -> no beat lost or duplicated, wr_rdy=0 only while num_used=4.
- fthresh=2, ethresh=1: write 1-beat packets -> tfull rises at num_used=2, tempty falls at num_vld=2.
- flush during partial packet with committed data resident -> next cycle all counts 0, empty=1, err_ovsz=0, state IDLE; rst_n pulse mid-write gives identical state.

Source files
------------

// File: rtl/sfifo_pkt.sv
// Store-and-forward packet FIFO: readers only ever see fully committed packets.
// Latency: an eop beat accepted in cycle N is readable in N+1; status and counts are registered.
// Backpressure: wr_rdy drops when storage is full, except while swallowing an oversize packet.
module sfifo_pkt #(
    parameter int DEPTH       = 4,
    parameter int WIDTH       = 8,
    parameter int NO_DATA_RST = 0,
    parameter int NV_WIDTH    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                wr_vld,
    output logic                wr_rdy,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                wr_eop,
    input  logic                wr_drop,
    output logic                rd_vld,
    input  logic                rd_rdy,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_eop,
    input  logic [NV_WIDTH-1:0] fthresh,
    input  logic [NV_WIDTH-1:0] ethresh,
    output logic                full,
    output logic                tfull,
    output logic                empty,
    output logic                tempty,
    output logic [NV_WIDTH-1:0] num_vld,
    output logic [NV_WIDTH-1:0] num_used,
    output logic [NV_WIDTH-1:0] num_pkts,
    output logic                pkt_dropped,
    output logic                err_ovsz
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [NV_WIDTH-1:0] W_DEPTH = NV_WIDTH'(DEPTH);
    localparam logic [PW-1:0]       W_LAST  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_DISCARD} state_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_wr_ptr, r_cmt_ptr, r_rd_ptr;
    logic [PW-1:0]       w_wr_ptr_nxt, w_cmt_ptr_nxt;
    logic [NV_WIDTH-1:0] r_u, r_num_vld, r_num_used, r_num_pkts;
    logic [NV_WIDTH-1:0] w_u_nxt, w_num_vld_nxt, w_num_used_nxt, w_num_pkts_nxt;
    logic                r_pkt_dropped, r_err_ovsz;
    logic                w_wr_acc, w_rd_acc, w_store, w_commit, w_drop, w_ovsz;
    logic [WIDTH:0]      r_mem [DEPTH];

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == W_LAST) ? '0 : p + 1'b1;
    endfunction

    assign wr_rdy   = (r_num_used < W_DEPTH) | (r_state == S_DISCARD);
    assign rd_vld   = (r_num_vld != '0);
    assign w_wr_acc = wr_vld & wr_rdy;
    assign w_rd_acc = rd_vld & rd_rdy;
    assign rd_data  = r_mem[r_rd_ptr][WIDTH-1:0];
    assign rd_eop   = r_mem[r_rd_ptr][WIDTH];

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_cmt_ptr_nxt = r_cmt_ptr;
        w_u_nxt       = r_u;
        w_store       = 1'b0;
        w_commit      = 1'b0;
        w_drop        = 1'b0;
        w_ovsz        = 1'b0;
        case (r_state)
            S_IDLE, S_PKT: begin
                if (wr_drop && ((r_state == S_PKT) || w_wr_acc)) begin
                    w_drop       = 1'b1;
                    w_wr_ptr_nxt = r_cmt_ptr;
                    w_u_nxt      = '0;
                    w_state_nxt  = S_IDLE;
                end else if ((r_state == S_PKT) && (r_u == W_DEPTH)) begin
                    w_ovsz       = 1'b1;
                    w_wr_ptr_nxt = r_cmt_ptr;
                    w_u_nxt      = '0;
                    w_state_nxt  = S_DISCARD;
                end else if (w_wr_acc) begin
                    w_store      = 1'b1;
                    w_wr_ptr_nxt = f_inc(r_wr_ptr);
                    if (wr_eop) begin
                        w_commit      = 1'b1;
                        w_cmt_ptr_nxt = f_inc(r_wr_ptr);
                        w_u_nxt       = '0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_u_nxt     = r_u + 1'b1;
                        w_state_nxt = S_PKT;
                    end
                end
            end
            S_DISCARD: begin
                if (w_wr_acc && wr_eop) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The u beats of a packet are already in num_used; committing only moves them into num_vld.
    always_comb begin
        w_num_vld_nxt  = r_num_vld + (w_commit ? r_u + 1'b1 : '0) - NV_WIDTH'(w_rd_acc);
        w_num_used_nxt = r_num_used + NV_WIDTH'(w_store) - NV_WIDTH'(w_rd_acc)
                       - ((w_drop | w_ovsz) ? r_u : '0);
        w_num_pkts_nxt = r_num_pkts + NV_WIDTH'(w_commit) - NV_WIDTH'(w_rd_acc & rd_eop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_cmt_ptr     <= '0;
            r_rd_ptr      <= '0;
            r_u           <= '0;
            r_num_vld     <= '0;
            r_num_used    <= '0;
            r_num_pkts    <= '0;
            r_pkt_dropped <= 1'b0;
            r_err_ovsz    <= 1'b0;
        end else if (flush) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_cmt_ptr     <= '0;
            r_rd_ptr      <= '0;
            r_u           <= '0;
            r_num_vld     <= '0;
            r_num_used    <= '0;
            r_num_pkts    <= '0;
            r_pkt_dropped <= 1'b0;
            r_err_ovsz    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_cmt_ptr     <= w_cmt_ptr_nxt;
            r_rd_ptr      <= w_rd_acc ? f_inc(r_rd_ptr) : r_rd_ptr;
            r_u           <= w_u_nxt;
            r_num_vld     <= w_num_vld_nxt;
            r_num_used    <= w_num_used_nxt;
            r_num_pkts    <= w_num_pkts_nxt;
            r_pkt_dropped <= w_drop | w_ovsz;
            r_err_ovsz    <= r_err_ovsz | w_ovsz;
        end
    end

    generate
        if (NO_DATA_RST == 0) begin : g_mem_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
                end else if (w_store && !flush) begin
                    r_mem[r_wr_ptr] <= {wr_eop, wr_data};
                end
            end
        end else begin : g_mem_nrst
            always_ff @(posedge clk) begin
                if (w_store && !flush) r_mem[r_wr_ptr] <= {wr_eop, wr_data};
            end
        end
    endgenerate

    assign num_vld     = r_num_vld;
    assign num_used    = r_num_used;
    assign num_pkts    = r_num_pkts;
    assign full        = (r_num_used == W_DEPTH);
    assign empty       = (r_num_vld == '0);
    assign tfull       = (r_num_used >= fthresh);
    assign tempty      = (r_num_vld <= ethresh);
    assign pkt_dropped = r_pkt_dropped;
    assign err_ovsz    = r_err_ovsz;

endmodule

// File: tb/tb_sfifo_pkt.sv
// Directed bench for sfifo_pkt (DEPTH=4, WIDTH=8) with hand-computed expectations.
module tb_sfifo_pkt;

    logic       clk = 1'b0;
    logic       rst_n, flush, wr_vld, wr_rdy, wr_eop, wr_drop;
    logic       rd_vld, rd_rdy, rd_eop;
    logic [7:0] wr_data, rd_data;
    logic [2:0] fthresh, ethresh, num_vld, num_used, num_pkts;
    logic       full, tfull, empty, tempty, pkt_dropped, err_ovsz;

    int n_cmp = 0;
    int n_bad = 0;

    sfifo_pkt #(.DEPTH(4), .WIDTH(8), .NO_DATA_RST(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data), .wr_eop(wr_eop), .wr_drop(wr_drop),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_data(rd_data), .rd_eop(rd_eop),
        .fthresh(fthresh), .ethresh(ethresh),
        .full(full), .tfull(tfull), .empty(empty), .tempty(tempty),
        .num_vld(num_vld), .num_used(num_used), .num_pkts(num_pkts),
        .pkt_dropped(pkt_dropped), .err_ovsz(err_ovsz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic eop);
        wr_vld = 1'b1; wr_data = d; wr_eop = eop;
        chk("wr_rdy", wr_rdy, 1);
        tick();
        wr_vld = 1'b0; wr_eop = 1'b0;
    endtask

    task automatic rd(input logic [7:0] d, input logic eop);
        chk("rd_vld", rd_vld, 1);
        chk("rd_data", rd_data, d);
        chk("rd_eop", rd_eop, eop);
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_vld = 1'b0; wr_data = '0; wr_eop = 1'b0;
        wr_drop = 1'b0; rd_rdy = 1'b0; fthresh = 3'd4; ethresh = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst wr_rdy", wr_rdy, 1);
        chk("rst rd_vld", rd_vld, 0);
        chk("rst rd_data", rd_data, 0);
        chk("rst rd_eop", rd_eop, 0);
        chk("rst full", full, 0);
        chk("rst tfull", tfull, 0);
        chk("rst empty", empty, 1);
        chk("rst tempty", tempty, 1);
        chk("rst counts", {num_vld, num_used, num_pkts}, 0);
        chk("rst flags", {pkt_dropped, err_ovsz}, 0);
        rst_n = 1'b1;
        tick();

        // store-and-forward: nothing visible until eop
        wr(8'h11, 1'b0);
        chk("t1 rd_vld b1", rd_vld, 0);
        chk("t1 used b1", num_used, 1);
        wr(8'h22, 1'b0);
        chk("t1 rd_vld b2", rd_vld, 0);
        wr(8'h33, 1'b1);
        chk("t1 rd_vld eop", rd_vld, 1);
        chk("t1 num_vld", num_vld, 3);
        chk("t1 num_pkts", num_pkts, 1);
        rd(8'h11, 1'b0);
        rd(8'h22, 1'b0);
        rd(8'h33, 1'b1);
        chk("t1 empty", empty, 1);
        chk("t1 num_pkts end", num_pkts, 0);

        // explicit drop
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        wr_drop = 1'b1;
        tick();
        wr_drop = 1'b0;
        chk("t2 pulse", pkt_dropped, 1);
        chk("t2 used", num_used, 0);
        chk("t2 rd_vld", rd_vld, 0);
        tick();
        chk("t2 pulse end", pkt_dropped, 0);
        chk("t2 rd_vld later", rd_vld, 0);
        wr(8'hAA, 1'b1);
        rd(8'hAA, 1'b1);

        // oversize packet
        wr(8'h41, 1'b0);
        wr(8'h42, 1'b0);
        wr(8'h43, 1'b0);
        wr(8'h44, 1'b0);
        chk("t3 used 4", num_used, 4);
        chk("t3 wr_rdy 0", wr_rdy, 0);
        tick();
        chk("t3 err_ovsz", err_ovsz, 1);
        chk("t3 pulse", pkt_dropped, 1);
        chk("t3 used 0", num_used, 0);
        chk("t3 wr_rdy 1", wr_rdy, 1);
        wr(8'h45, 1'b0);
        wr(8'h46, 1'b1);
        chk("t3 swallowed used", num_used, 0);
        chk("t3 swallowed vld", rd_vld, 0);
        wr(8'h50, 1'b1);
        rd(8'h50, 1'b1);
        chk("t3 err sticky", err_ovsz, 1);

        // fill, then drain while writing a second packet
        wr(8'h61, 1'b0);
        wr(8'h62, 1'b0);
        wr(8'h63, 1'b0);
        wr(8'h64, 1'b1);
        chk("t4 full", full, 1);
        chk("t4 num_pkts", num_pkts, 1);
        rd_rdy = 1'b1; wr_vld = 1'b1; wr_data = 8'h71; wr_eop = 1'b0;
        chk("t4 A wr_rdy", wr_rdy, 0);
        chk("t4 A rd_data", rd_data, 8'h61);
        tick();
        chk("t4 A used", num_used, 3);
        chk("t4 B wr_rdy", wr_rdy, 1);
        chk("t4 B rd_data", rd_data, 8'h62);
        tick();
        chk("t4 B used", num_used, 3);
        wr_data = 8'h72; wr_eop = 1'b1;
        chk("t4 C wr_rdy", wr_rdy, 1);
        chk("t4 C rd_data", rd_data, 8'h63);
        tick();
        chk("t4 C num_vld", num_vld, 3);
        chk("t4 C num_pkts", num_pkts, 2);
        wr_vld = 1'b0; wr_eop = 1'b0;
        chk("t4 D rd_data", {rd_eop, rd_data}, 9'h164);
        tick();
        chk("t4 D num_pkts", num_pkts, 1);
        chk("t4 E rd_data", {rd_eop, rd_data}, 9'h071);
        tick();
        chk("t4 F rd_data", {rd_eop, rd_data}, 9'h172);
        tick();
        rd_rdy = 1'b0;
        chk("t4 empty", empty, 1);
        chk("t4 used", num_used, 0);

        // thresholds
        fthresh = 3'd2; ethresh = 3'd1;
        #1;
        chk("t5 tfull 0", tfull, 0);
        chk("t5 tempty 0", tempty, 1);
        wr(8'h81, 1'b1);
        chk("t5 tfull 1", tfull, 0);
        chk("t5 tempty 1", tempty, 1);
        wr(8'h82, 1'b1);
        chk("t5 tfull 2", tfull, 1);
        chk("t5 tempty 2", tempty, 0);
        rd(8'h81, 1'b1);
        chk("t5 tfull r", tfull, 0);
        chk("t5 tempty r", tempty, 1);
        rd(8'h82, 1'b1);
        fthresh = 3'd4; ethresh = 3'd0;

        // flush with committed data and a partial packet resident
        wr(8'h91, 1'b1);
        wr(8'h92, 1'b0);
        chk("t6 used pre", num_used, 2);
        chk("t6 vld pre", num_vld, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6 counts", {num_vld, num_used, num_pkts}, 0);
        chk("t6 empty", empty, 1);
        chk("t6 err", err_ovsz, 0);
        chk("t6 rd_vld", rd_vld, 0);
        chk("t6 pulse", pkt_dropped, 0);
        wr(8'hA5, 1'b1);
        rd(8'hA5, 1'b1);

        // asynchronous reset mid-packet
        wr(8'hB1, 1'b1);
        wr(8'hB2, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t7 counts", {num_vld, num_used, num_pkts}, 0);
        chk("t7 empty", empty, 1);
        chk("t7 rd_data", rd_data, 0);
        chk("t7 flags", {pkt_dropped, err_ovsz, wr_rdy}, 3'b001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        wr(8'hC3, 1'b1);
        rd(8'hC3, 1'b1);
        chk("t7 end empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
